// File: rtl/mips_control_fsm_if.sv
// rtl/mips_control_fsm_if.sv - controller-to-datapath strobe bundle
interface mips_control_fsm_if;
  logic [5:0] op;
  logic       zero;
  logic       memread;
  logic       memwrite;
  logic       iord;
  logic       irwrite;
  logic       pcen;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsrc;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, zero,
    output memread, memwrite, iord, irwrite, pcen, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, illegal, state
  );

  modport slave (
    output op, zero,
    input  memread, memwrite, iord, irwrite, pcen, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, illegal, state
  );
endinterface

// File: rtl/mips_control_fsm.sv
// rtl/mips_control_fsm.sv - multicycle MIPS main controller with stretched memory states
module mips_control_fsm #(
  parameter int MEM_WAIT = 0
) (
  input logic               clk,
  input logic               reset,
  mips_control_fsm_if.master bus
);
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,  S_FETCH   = 4'd1,  S_DECODE  = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD   = 4'd4,  S_MEMWB   = 4'd5,  S_MEMWR   = 4'd6,  S_RTYPEEX = 4'd7,
    S_RTYPEWB = 4'd8,  S_BEQEX   = 4'd9,  S_ADDIEX  = 4'd10, S_ADDIWB = 4'd11,
    S_JEX     = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       wait_done;
  logic       illegal_d;
  logic       pcwrite, branch;

  assign wait_done = (cnt_q == WAIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (wait_done) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYP:      state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (wait_done) state_d = S_MEMWB;
      S_MEMWR:   if (wait_done) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase

    // Only the memory states self-loop, so any state change is an entry that clears the count.
    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = 3'd0;
    else if (cnt_q < WAIT_LAST)
      cnt_d = cnt_q + 3'd1;
  end

  always_comb begin
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    bus.iord     = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regwrite = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.aluop    = 2'b00;
    bus.pcsrc    = 2'b00;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.memread = 1'b1;
        bus.alusrcb = 2'b01;
        bus.irwrite = wait_done;
        pcwrite     = wait_done;
      end
      S_DECODE: bus.alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        bus.memread = 1'b1;
        bus.iord    = 1'b1;
      end
      S_MEMWR: begin
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
      end
      S_MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
      end
      S_RTYPEEX: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b10;
      end
      S_RTYPEWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
      end
      S_ADDIWB: bus.regwrite = 1'b1;
      S_BEQEX: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b01;
        bus.pcsrc   = 2'b01;
        branch      = 1'b1;
      end
      S_JEX: begin
        bus.pcsrc = 2'b10;
        pcwrite   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pcen    = pcwrite | (branch & bus.zero);
  assign bus.illegal = illegal_d;
  assign bus.state   = state_q;
endmodule
